// File: rtl/game_view_pkg.sv
// Shared definitions for the game view redraw path: state codes, class IDs and
// a width helper used by the sequencer, its interface and the bench.
package game_view_pkg;

    // State encoding
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_BG    = 3'd1;
    localparam logic [2:0] ST_RX    = 3'd2;
    localparam logic [2:0] ST_RY    = 3'd3;
    localparam logic [2:0] ST_OBJ   = 3'd4;
    localparam logic [2:0] ST_HOOK  = 3'd5;
    localparam logic [2:0] ST_FWAIT = 3'd6;
    localparam logic [2:0] ST_DONE  = 3'd7;

    typedef enum logic [2:0] {
        StIdle  = ST_IDLE,
        StBg    = ST_BG,
        StRx    = ST_RX,
        StRy    = ST_RY,
        StObj   = ST_OBJ,
        StHook  = ST_HOOK,
        StFwait = ST_FWAIT,
        StDone  = ST_DONE
    } state_e;

    // Object class identifiers
    localparam int unsigned CLASS_GOLD    = 0;
    localparam int unsigned CLASS_STONE   = 1;
    localparam int unsigned CLASS_DIAMOND = 2;

    // Bits needed to index n items, never less than one
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/scene_draw_sequencer_if.sv
// Handshake bundle between the redraw sequencer, the game logic and the
// draw/random datapath. master = sequencer side, slave = environment side.
interface scene_draw_sequencer_if #(
    parameter int unsigned N_CLASS = 3,
    parameter int unsigned MAX_OBJ = 5
);
    import game_view_pkg::*;

    localparam int unsigned CLS_W = clog2_min1(N_CLASS);
    localparam int unsigned IDX_W = clog2_min1(MAX_OBJ);

    // Game logic controls
    logic               go;
    logic               frame_tick;
    logic               game_end;
    logic [N_CLASS-1:0] class_en;

    // Draw engine handshakes
    logic               bg_done;
    logic               obj_done;
    logic               hook_done;
    logic               bg_start;
    logic               obj_start;
    logic               hook_start;
    logic [CLS_W-1:0]   obj_class;
    logic [IDX_W-1:0]   obj_index;

    // Random generator and store control, status
    logic               rand_en;
    logic               rand_sel;
    logic               scene_clear;
    logic               busy;
    logic               err;

    modport master (
        input  go, frame_tick, game_end, class_en, bg_done, obj_done, hook_done,
        output bg_start, obj_start, hook_start, obj_class, obj_index,
               rand_en, rand_sel, scene_clear, busy, err
    );

    modport slave (
        output go, frame_tick, game_end, class_en, bg_done, obj_done, hook_done,
        input  bg_start, obj_start, hook_start, obj_class, obj_index,
               rand_en, rand_sel, scene_clear, busy, err
    );

endinterface

// File: rtl/handshake_watchdog.sv
// Shared done/timeout detector for the BG, OBJ and HOOK wait states. The
// counter holds the number of cycles since the current wait state was entered.
module handshake_watchdog #(
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic clk,
    input  logic reset,
    input  logic active,     // FSM is in a wait state
    input  logic start,      // entry cycle of that wait state
    input  logic done,       // done input of the engine being waited on
    output logic fire,       // done or timeout, never on the entry cycle
    output logic timed_out
);

    localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_VAL = TO_W'(TIMEOUT);

    logic [TO_W-1:0] wd_q;
    logic [TO_W-1:0] wd_d;
    logic            expired;

    // Entry cycle counts as zero, so the register reads 1 on entry+1
    always_comb begin
        wd_d = wd_q;
        if (start) begin
            wd_d = TO_W'(1);
        end else if (active && (wd_q != TO_VAL)) begin
            wd_d = wd_q + TO_W'(1);
        end
    end

    // Watchdog counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end

    // Done on the entry cycle is ignored
    always_comb begin
        expired   = (wd_q == TO_VAL);
        fire      = active && !start && (done || expired);
        timed_out = active && !start && !done && expired;
    end

endmodule

// File: rtl/scene_draw_sequencer.sv
// Per-frame redraw sequencer: background, each enabled object class, then the
// hook. Random X/Y are loaded only while the round's layout is not yet valid.
module scene_draw_sequencer
    import game_view_pkg::*;
#(
    parameter int unsigned N_CLASS = 3,
    parameter int unsigned MAX_OBJ = 5,
    parameter int unsigned TIMEOUT = 1023
) (
    input logic                   clk,
    input logic                   reset,
    scene_draw_sequencer_if.master bus
);

    localparam int unsigned CLS_W = clog2_min1(N_CLASS);
    localparam int unsigned IDX_W = clog2_min1(MAX_OBJ);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MAX_OBJ - 1);

    state_e           state_q, state_d;
    logic [CLS_W-1:0] cls_q, cls_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             layout_q, layout_d;
    logic             first_q, first_d;
    logic             err_q, err_d;

    logic             clear;
    logic             lo_found, up_found;
    logic [CLS_W-1:0] lo_cls, up_cls;
    logic             wait_active, wait_done;
    logic             fire, timed_out;
    state_e           obj_entry;

    // Lowest enabled class overall, and lowest enabled class above cls
    always_comb begin
        lo_found = 1'b0;
        lo_cls   = '0;
        up_found = 1'b0;
        up_cls   = '0;
        for (int i = N_CLASS - 1; i >= 0; i--) begin
            if (bus.class_en[i]) begin
                lo_found = 1'b1;
                lo_cls   = CLS_W'(i);
            end
            if (bus.class_en[i] && (i > int'(cls_q))) begin
                up_found = 1'b1;
                up_cls   = CLS_W'(i);
            end
        end
    end

    // Select the done input belonging to the current wait state
    always_comb begin
        wait_active = 1'b0;
        wait_done   = 1'b0;
        case (state_q)
            StBg: begin
                wait_active = 1'b1;
                wait_done   = bus.bg_done;
            end
            StObj: begin
                wait_active = 1'b1;
                wait_done   = bus.obj_done;
            end
            StHook: begin
                wait_active = 1'b1;
                wait_done   = bus.hook_done;
            end
            default: begin
                wait_active = 1'b0;
                wait_done   = 1'b0;
            end
        endcase
    end

    handshake_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .active   (wait_active),
        .start    (first_q),
        .done     (wait_done),
        .fire     (fire),
        .timed_out(timed_out)
    );

    // Next-state logic; first_d marks entry into a wait state, including OBJ->OBJ
    always_comb begin
        state_d   = state_q;
        cls_d     = cls_q;
        idx_d     = idx_q;
        layout_d  = layout_q;
        first_d   = 1'b0;
        clear     = 1'b0;
        err_d     = err_q | timed_out;
        obj_entry = layout_q ? StObj : StRx;
        case (state_q)
            StIdle, StDone: begin
                if (bus.go) begin
                    state_d  = StBg;
                    layout_d = 1'b0;
                    clear    = 1'b1;
                    first_d  = 1'b1;
                end
            end
            StBg: begin
                if (fire) begin
                    if (lo_found) begin
                        cls_d   = lo_cls;
                        idx_d   = '0;
                        state_d = obj_entry;
                        first_d = layout_q;
                    end else begin
                        state_d = StHook;
                        first_d = 1'b1;
                    end
                end
            end
            StRx: begin
                state_d = StRy;
            end
            StRy: begin
                state_d = StObj;
                first_d = 1'b1;
            end
            StObj: begin
                if (fire) begin
                    if (idx_q != IDX_LAST) begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = obj_entry;
                        first_d = layout_q;
                    end else if (up_found) begin
                        cls_d   = up_cls;
                        idx_d   = '0;
                        state_d = obj_entry;
                        first_d = layout_q;
                    end else begin
                        state_d = StHook;
                        first_d = 1'b1;
                    end
                end
            end
            StHook: begin
                if (fire) begin
                    state_d  = StFwait;
                    layout_d = 1'b1;
                end
            end
            StFwait: begin
                // game_end has priority over a coincident tick
                if (bus.game_end) begin
                    state_d = StDone;
                end else if (bus.frame_tick) begin
                    state_d = StBg;
                    first_d = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            cls_q    <= '0;
            idx_q    <= '0;
            layout_q <= 1'b0;
            first_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cls_q    <= cls_d;
            idx_q    <= idx_d;
            layout_q <= layout_d;
            first_q  <= first_d;
            err_q    <= err_d;
        end
    end

    // Outputs decoded from state; scene_clear is gated so reset forces it low
    always_comb begin
        bus.bg_start    = first_q && (state_q == StBg);
        bus.obj_start   = first_q && (state_q == StObj);
        bus.hook_start  = first_q && (state_q == StHook);
        bus.obj_class   = cls_q;
        bus.obj_index   = idx_q;
        bus.rand_en     = (state_q == StRx) || (state_q == StRy);
        bus.rand_sel    = (state_q == StRy);
        bus.scene_clear = clear && !reset;
        bus.busy        = (state_q != StIdle) && (state_q != StDone);
        bus.err         = err_q;
    end

endmodule

// File: tb/tb_scene_draw_sequencer.sv
// Directed bench for scene_draw_sequencer with an object-order scoreboard.
module tb_scene_draw_sequencer;
    import game_view_pkg::*;

    logic clk;
    logic reset;

    scene_draw_sequencer_if #(.N_CLASS(3), .MAX_OBJ(5)) bus ();

    scene_draw_sequencer #(
        .N_CLASS(3),
        .MAX_OBJ(5),
        .TIMEOUT(1023)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    int cyc = 0;
    int n_obj = 0, n_rand = 0, n_bg = 0, n_hook = 0, n_clear = 0;
    int t_bg = 0, t_hook = 0, t_clear = 0, t_tick = 0, t_obj = 0, t_obj_prev = 0;
    int busy_lo = 0, wide = 0;
    bit in_frame = 0;
    bit prev_starts = 0;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int out_vec();
        return int'({bus.bg_start, bus.obj_start, bus.hook_start, bus.obj_class,
                     bus.obj_index, bus.rand_en, bus.rand_sel, bus.scene_clear,
                     bus.busy, bus.err});
    endfunction

    // Monitor work done once per cycle at the falling edge
    task automatic sample();
        int e;
        cyc++;
        if (bus.obj_start) begin
            n_obj++;
            t_obj_prev = t_obj;
            t_obj = cyc;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
            check("obj_order", int'(bus.obj_class) * 16 + int'(bus.obj_index), e);
        end
        if (bus.bg_start || bus.obj_start || bus.hook_start) begin
            if (prev_starts && (bus.bg_start || bus.hook_start)) wide++;
        end
        prev_starts = bus.bg_start || bus.obj_start || bus.hook_start;
        if (bus.rand_en) n_rand++;
        if (bus.scene_clear) begin
            n_clear++;
            t_clear = cyc;
        end
        if (bus.frame_tick) t_tick = cyc;
        if (bus.bg_start) begin
            n_bg++;
            t_bg = cyc;
            in_frame = 1;
        end
        if (in_frame && !bus.busy) busy_lo++;
        if (bus.hook_start) begin
            n_hook++;
            t_hook = cyc;
            in_frame = 0;
        end
    endtask

    task automatic step();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_hook(input int base, input int limit);
        int k = 0;
        while (n_hook == base && k < limit) begin
            step();
            k++;
        end
        check("hook_seen", n_hook - base, 1);
    endtask

    task automatic wait_obj(input int target, input int limit);
        int k = 0;
        while (n_obj < target && k < limit) begin
            step();
            k++;
        end
        check("obj_reached", n_obj, target);
    endtask

    task automatic push_frame(input logic [2:0] en);
        for (int c = 0; c < 3; c++) begin
            if (en[c]) begin
                for (int i = 0; i < 5; i++) exp_q.push_back(c * 16 + i);
            end
        end
    endtask

    // Drive a one-cycle frame_tick from FWAIT
    task automatic tick();
        bus.frame_tick = 1'b1;
        step();
        bus.frame_tick = 1'b0;
    endtask

    initial begin
        int b_obj, b_rand, b_bg, b_hook, b_sum;
        logic [2:0] en;
        reset          = 1'b1;
        bus.go         = 1'b0;
        bus.frame_tick = 1'b0;
        bus.game_end   = 1'b0;
        bus.class_en   = 3'b000;
        bus.bg_done    = 1'b1;
        bus.obj_done   = 1'b1;
        bus.hook_done  = 1'b1;

        // Reset state
        repeat (3) step();
        check("reset_outputs", out_vec(), 0);
        reset = 1'b0;
        repeat (3) step();
        check("idle_no_pulse", n_bg + n_obj + n_hook + n_rand, 0);
        check("idle_busy", int'(bus.busy), 0);

        // First frame: all classes, random positions requested
        bus.class_en = 3'b111;
        push_frame(3'b111);
        bus.go = 1'b1;
        step();
        bus.go = 1'b0;
        check("go_scene_clear", n_clear, 1);
        wait_hook(0, 200);
        check("go_to_bg_latency", t_bg - t_clear, 1);
        check("f1_obj_count", n_obj, 15);
        check("f1_rand_count", n_rand, 30);
        check("f1_length", t_hook - t_bg + 2, 64);
        check("f1_busy_low_cycles", busy_lo, 0);
        check("f1_queue_left", exp_q.size(), 0);
        step();
        check("fwait_busy", int'(bus.busy), 1);

        // Second frame: stored layout, no random loads
        b_obj = n_obj;
        b_rand = n_rand;
        b_hook = n_hook;
        push_frame(3'b111);
        tick();
        wait_hook(b_hook, 200);
        check("tick_to_bg_latency", t_bg - t_tick, 1);
        check("f2_obj_count", n_obj - b_obj, 15);
        check("f2_rand_count", n_rand - b_rand, 0);
        check("f2_length", t_hook - t_bg + 2, 34);
        step();

        // Only the stone class enabled
        en = 3'b000;
        en[CLASS_STONE] = 1'b1;
        bus.class_en = en;
        b_obj = n_obj;
        b_hook = n_hook;
        push_frame(en);
        tick();
        wait_hook(b_hook, 200);
        check("stone_obj_count", n_obj - b_obj, 5);
        check("stone_length", t_hook - t_bg + 2, 14);
        step();

        // No class enabled: background straight to hook
        bus.class_en = 3'b000;
        b_obj = n_obj;
        b_hook = n_hook;
        tick();
        wait_hook(b_hook, 200);
        check("empty_obj_count", n_obj - b_obj, 0);
        check("empty_length", t_hook - t_bg + 2, 4);
        step();

        // obj_done stuck low: watchdog expires after 1023 wait cycles
        en = 3'b000;
        en[CLASS_GOLD] = 1'b1;
        bus.class_en = en;
        bus.obj_done = 1'b0;
        b_obj = n_obj;
        b_hook = n_hook;
        check("err_before_timeout", int'(bus.err), 0);
        push_frame(en);
        tick();
        wait_obj(b_obj + 1, 50);
        check("err_during_wait", int'(bus.err), 0);
        wait_obj(b_obj + 2, 1100);
        check("timeout_gap", t_obj - t_obj_prev, 1024);
        check("err_after_timeout", int'(bus.err), 1);
        bus.obj_done = 1'b1;
        wait_hook(b_hook, 200);
        check("timeout_obj_count", n_obj - b_obj, 5);
        step();
        check("err_sticky", int'(bus.err), 1);

        // game_end wins over a coincident frame_tick
        b_bg = n_bg;
        bus.game_end = 1'b1;
        bus.frame_tick = 1'b1;
        step();
        bus.game_end = 1'b0;
        bus.frame_tick = 1'b0;
        repeat (3) step();
        check("end_no_bg", n_bg - b_bg, 0);
        check("done_busy", int'(bus.busy), 0);

        // go from DONE: clear, new round with random loads again
        bus.class_en = 3'b111;
        b_obj = n_obj;
        b_rand = n_rand;
        b_hook = n_hook;
        b_sum = n_clear;
        push_frame(3'b111);
        bus.go = 1'b1;
        step();
        bus.go = 1'b0;
        check("done_go_clear", n_clear - b_sum, 1);
        wait_hook(b_hook, 200);
        check("done_go_bg_latency", t_bg - t_clear, 1);
        check("r2_rand_count", n_rand - b_rand, 30);
        check("r2_obj_count", n_obj - b_obj, 15);
        check("r2_err_still_set", int'(bus.err), 1);
        check("start_pulse_width", wide, 0);
        step();

        // Asynchronous reset in the middle of an OBJ wait
        b_obj = n_obj;
        push_frame(3'b111);
        tick();
        wait_obj(b_obj + 3, 100);
        #2;
        reset = 1'b1;
        in_frame = 0;
        #1;
        check("midobj_reset_outputs", out_vec(), 0);
        exp_q.delete();
        repeat (2) step();
        reset = 1'b0;
        b_sum = n_bg + n_obj + n_hook + n_rand + n_clear;
        repeat (5) step();
        check("post_reset_quiet", n_bg + n_obj + n_hook + n_rand + n_clear - b_sum, 0);
        check("post_reset_busy", int'(bus.busy), 0);
        check("post_reset_err", int'(bus.err), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/scene_draw_sequencer.md
# scene_draw_sequencer

Control FSM for the game view's per-frame redraw. It sequences background, N classes of scene objects (gold, stone, diamond, ...) and the hook through start/done handshakes with the draw engines. It requests random X/Y only on the first frame of a round and re-draws stored positions on later frames. Frame-tick gating, a per-class enable mask and a watchdog on every handshake are included. It sits between the game logic (go, game_end, frame_tick) and the draw/random datapath.

## Interface
Parameters:
- `N_CLASS`, default 3: number of object classes.
- `MAX_OBJ`, default 5: objects drawn per enabled class, ≥1.
- `TIMEOUT`, default 1023: maximum cycles to wait for any done signal.

Ports:
- `clk` in 1: system clock; all logic is rising-edge.
- `reset` in 1: asynchronous, active-high; forces the reset state below.
- `go` in 1: level; starts a round from IDLE or DONE.
- `frame_tick` in 1: one-cycle pulse per display frame.
- `game_end` in 1: level from game logic.
- `class_en` in N_CLASS: per-class draw enable, sampled when the class is entered.
- `bg_done`, `obj_done`, `hook_done` in 1 each: completion pulses or levels from the draw engines.
- `bg_start`, `obj_start`, `hook_start` out 1 each: one-cycle start pulses.
- `obj_class` out CLS_W: class of the current object.
- `obj_index` out IDX_W: index of the current object within its class.
- `rand_en` out 1: random-generator load strobe.
- `rand_sel` out 1: 0 loads X, 1 loads Y.
- `scene_clear` out 1: one-cycle pulse that clears the object/position store.
- `busy` out 1: high in every state except IDLE and DONE.
- `err` out 1: sticky flag, set on a handshake timeout.

## Operation
- Widths: CLS_W = max(1, clog2(N_CLASS)); IDX_W = max(1, clog2(MAX_OBJ)); TO_W = clog2(TIMEOUT+1).
- States: IDLE, BG, RX, RY, OBJ, HOOK, FWAIT, DONE.
- Internal registers:
  - `cls` and `idx` counters.
  - `layout_valid`: 0 until the first complete frame of a round.
  - `wd`: watchdog counter.
  - `first`: marks the entry cycle of a wait state.
- IDLE: on go → BG; layout_valid←0; scene_clear pulses on that transition.
- BG:
  - bg_start pulses on the entry cycle.
  - bg_done is sampled from entry+1 onward.
  - On done → object scan with cls←lowest enabled class, idx←0.
  - If no class is enabled → HOOK.
- Object scan, per (cls, idx):
  - If layout_valid=0: RX (rand_en=1, rand_sel=0, 1 cycle), then RY (rand_en=1, rand_sel=1, 1 cycle), then OBJ.
  - Otherwise go directly to OBJ.
  - OBJ: obj_start pulses on entry; obj_class/obj_index hold until obj_done.
  - Advance: idx+1. On idx=MAX_OBJ-1, set idx←0 and cls←next enabled class above cls. When no enabled class remains → HOOK.
- HOOK: hook_start pulses on entry; on hook_done → FWAIT; layout_valid←1.
- FWAIT: if game_end → DONE, else on frame_tick → BG. If both are high in the same cycle, game_end wins.
- DONE: on go → BG; layout_valid←0; scene_clear pulses.
- Watchdog:
  - wd clears on entry to BG, OBJ and HOOK, and increments while waiting.
  - When wd reaches TIMEOUT, err←1 and the FSM proceeds exactly as if done had arrived.
  - err clears only on reset.
- Ignored inputs:
  - go outside IDLE/DONE.
  - Done inputs outside their own wait state.
  - frame_tick outside FWAIT. A tick missed while drawing is dropped, not queued.
- class_en changes mid-frame affect only classes not yet entered.

## Timing
- Reset values:
  - State IDLE; cls=0, idx=0; layout_valid=0; err=0.
  - All outputs 0, including obj_class and obj_index.
- Reset asserted mid-frame aborts immediately. No start pulse is issued in the reset cycle or the first cycle after release.
- Minimum first frame with all classes enabled and every done arriving at entry+1: 2 (BG) + N_CLASS·MAX_OBJ·4 + 2 (HOOK) cycles from BG entry to FWAIT.
- Each later frame costs 2 cycles per object instead of 4.
- go→bg_start latency is 1 cycle from the go sample. FWAIT→bg_start is 1 cycle after the frame_tick sample.
- Start pulses are exactly one cycle wide. A done that is high on the entry cycle is ignored.

## Structure
- Shared package `game_view_pkg`:
  - State encoding localparams.
  - Function `clog2_min1`.
  - Class ID constants CLASS_GOLD=0, CLASS_STONE=1, CLASS_DIAMOND=2.
- One sub-module: `handshake_watchdog`. It takes start, done and TIMEOUT, and outputs `fire` (done-or-timeout, masked on the entry cycle) and `timed_out`. It is instantiated once and shared across BG/OBJ/HOOK.

## Test plan
- Reset, then go=1 with class_en=3'b111 and done at entry+1 → 15 obj_start pulses in order (0,0)…(2,4), 30 rand_en pulses, first frame length 64 cycles, busy=1 throughout.
- Second frame_tick after layout_valid=1 → 15 obj_start pulses, 0 rand_en pulses, frame length 34 cycles.
- class_en=3'b010 → only obj_class=1 with indices 0–4; class_en=0 → BG straight to HOOK.
- obj_done held low → after 1023 wait cycles err=1 and the next obj_start fires; err stays 1 until reset.
- game_end and frame_tick together in FWAIT → DONE, no bg_start; go then → scene_clear=1 and bg_start next cycle, rand_en active again.
- Async reset asserted mid-OBJ → all outputs 0 the same cycle; after release no pulse until go.
